// File: rtl/rfb_slice_scheduler_if.sv
// Handshake bundle between the slice scheduler, the RFB read port, the encoder
// strobe and the column-to-HUB75 converter.
interface rfb_slice_scheduler_if #(
  parameter int unsigned ANG_W    = 10,
  parameter int unsigned RAD_W    = 5,
  parameter int unsigned NUM_ROWS = 64
);
  logic                     angle_valid_in;
  logic [ANG_W-1:0]         angle_in;
  logic                     rfb_rd_en;
  logic [ANG_W-1:0]         rfb_rd_angle;
  logic [RAD_W-1:0]         rfb_rd_radius;
  logic [NUM_ROWS-1:0]      rfb_rd_data;
  logic [1:0][RAD_W-1:0]    radii_out;
  logic [1:0][NUM_ROWS-1:0] cols_out;
  logic                     cols_valid;
  logic                     hub75_ready;
  logic                     slice_done;
  logic                     overrun;

  // Scheduler side.
  modport master (
    input  angle_in, angle_valid_in, rfb_rd_data, hub75_ready,
    output rfb_rd_en, rfb_rd_angle, rfb_rd_radius, radii_out, cols_out, cols_valid,
           slice_done, overrun
  );

  // Environment side (encoder, RFB, converter).
  modport slave (
    output angle_in, angle_valid_in, rfb_rd_data, hub75_ready,
    input  rfb_rd_en, rfb_rd_angle, rfb_rd_radius, radii_out, cols_out, cols_valid,
           slice_done, overrun
  );
endinterface

// File: rtl/rfb_slice_scheduler.sv
// Walks all column pairs of one angular slice: two RFB reads per pair (angle A and
// the opposite angle), captures the returning words and hands each pair to the
// HUB75 converter over valid/ready. One pending strobe is buffered while busy.
module rfb_slice_scheduler #(
  parameter int unsigned ROTATIONAL_RES = 1024,
  parameter int unsigned SCAN_RATE      = 32,
  parameter int unsigned NUM_ROWS       = 64,
  parameter int unsigned RD_LAT         = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  rfb_slice_scheduler_if.master sched_io
);
  localparam int unsigned     AngW     = $clog2(ROTATIONAL_RES);
  localparam int unsigned     RadW     = $clog2(SCAN_RATE);
  localparam logic [AngW-1:0] HalfRot  = AngW'(ROTATIONAL_RES / 2);
  localparam logic [RadW-1:0] LastPair = RadW'(SCAN_RATE - 1);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWait, StPresent, StDone} state_e;

  state_e                   state_q;
  logic [AngW-1:0]          angle_q;
  logic [AngW-1:0]          pend_angle_q;
  logic                     pend_valid_q;
  logic [RadW-1:0]          p_q;
  logic                     rd_en_q;
  logic [AngW-1:0]          rd_angle_q;
  logic [RadW-1:0]          rd_radius_q;
  logic [1:0][RadW-1:0]     radii_q;
  logic [1:0][NUM_ROWS-1:0] cols_q;
  logic                     cols_valid_q;
  logic                     slice_done_q;
  logic                     overrun_q;
  // Side tags travel alongside outstanding reads; bit 0 is the newest issue.
  logic [RD_LAT-1:0]        tag_vld_q;
  logic [RD_LAT-1:0]        tag_side_q;
  logic                     side1_hit;

  assign side1_hit = tag_vld_q[RD_LAT-1] & tag_side_q[RD_LAT-1];

  // Main sequencer: pending-slot bookkeeping, read issue and the converter handshake.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      angle_q      <= '0;
      pend_angle_q <= '0;
      pend_valid_q <= 1'b0;
      p_q          <= '0;
      rd_en_q      <= 1'b0;
      rd_angle_q   <= '0;
      rd_radius_q  <= '0;
      radii_q      <= '0;
      cols_valid_q <= 1'b0;
      slice_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rd_en_q      <= 1'b0;
      slice_done_q <= 1'b0;
      overrun_q    <= 1'b0;

      // A strobe lands in the slot unless IDLE can take it directly; in IDLE the
      // slot is being drained the same cycle, so refilling it is not an overrun.
      if (sched_io.angle_valid_in && (state_q != StIdle || pend_valid_q)) begin
        pend_angle_q <= sched_io.angle_in;
        pend_valid_q <= 1'b1;
        overrun_q    <= pend_valid_q && (state_q != StIdle);
      end else if (state_q == StIdle) begin
        pend_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (pend_valid_q || sched_io.angle_valid_in) begin
            angle_q     <= pend_valid_q ? pend_angle_q : sched_io.angle_in;
            rd_angle_q  <= pend_valid_q ? pend_angle_q : sched_io.angle_in;
            rd_radius_q <= '0;
            rd_en_q     <= 1'b1;
            p_q         <= '0;
            state_q     <= StRd0;
          end
        end
        StRd0: begin
          rd_en_q     <= 1'b1;
          rd_angle_q  <= angle_q + HalfRot;
          rd_radius_q <= LastPair - p_q;
          state_q     <= StRd1;
        end
        StRd1: begin
          state_q <= StWait;
        end
        StWait: begin
          if (side1_hit) begin
            cols_valid_q <= 1'b1;
            radii_q      <= {LastPair - p_q, p_q};
            state_q      <= StPresent;
          end
        end
        StPresent: begin
          if (sched_io.hub75_ready) begin
            cols_valid_q <= 1'b0;
            if (p_q == LastPair) begin
              slice_done_q <= 1'b1;
              state_q      <= StDone;
            end else begin
              p_q         <= p_q + 1'b1;
              rd_en_q     <= 1'b1;
              rd_angle_q  <= angle_q;
              rd_radius_q <= p_q + 1'b1;
              state_q     <= StRd0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Read-latency tag pipe; steers each returning word into its side of cols_q.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_vld_q  <= '0;
      tag_side_q <= '0;
      cols_q     <= '0;
    end else begin
      tag_vld_q[0]  <= rd_en_q;
      tag_side_q[0] <= (state_q == StRd1);
      for (int i = 1; i < int'(RD_LAT); i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_side_q[i] <= tag_side_q[i-1];
      end
      if (tag_vld_q[RD_LAT-1]) begin
        cols_q[tag_side_q[RD_LAT-1]] <= sched_io.rfb_rd_data;
      end
    end
  end

  assign sched_io.rfb_rd_en     = rd_en_q;
  assign sched_io.rfb_rd_angle  = rd_angle_q;
  assign sched_io.rfb_rd_radius = rd_radius_q;
  assign sched_io.radii_out     = radii_q;
  assign sched_io.cols_out      = cols_q;
  assign sched_io.cols_valid    = cols_valid_q;
  assign sched_io.slice_done    = slice_done_q;
  assign sched_io.overrun       = overrun_q;

  // A side-1 hit outside WAIT would mean the tag pipe lost sync with the sequencer.
  property p_side1_in_wait;
    @(posedge clk_in) disable iff (!rst_n_in) side1_hit |-> (state_q == StWait);
  endproperty
  assert property (p_side1_in_wait);
endmodule

// File: tb/tb_rfb_slice_scheduler.sv
// Bench for rfb_slice_scheduler: an RFB model with fixed read latency, a passive
// monitor logging reads and accepted beats, and a slice-level reference model.
module tb_rfb_slice_scheduler;
  localparam int unsigned ROT = 1024;
  localparam int unsigned SR  = 32;
  localparam int unsigned NR  = 64;
  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 10;
  localparam int unsigned RW  = 5;

  typedef logic [AW+RW-1:0]     rd_t;
  typedef logic [2*RW+2*NR-1:0] beat_t;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  rfb_slice_scheduler_if #(.ANG_W(AW), .RAD_W(RW), .NUM_ROWS(NR)) bus ();

  rfb_slice_scheduler #(
    .ROTATIONAL_RES(ROT), .SCAN_RATE(SR), .NUM_ROWS(NR), .RD_LAT(LAT)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .sched_io(bus)
  );

  int    n_vec = 0;
  int    n_err = 0;
  int    exp_done = 0;
  int    exp_ovr = 0;
  int    done_cnt = 0;
  int    ovr_cnt = 0;
  rd_t   obs_rd[$];
  rd_t   exp_rd[$];
  beat_t obs_beat[$];
  beat_t exp_beat[$];

  // Content of the frame buffer: unique word per (angle, radius).
  function automatic logic [NR-1:0] rfb_word(input logic [AW-1:0] a, input logic [RW-1:0] r);
    logic [15:0] a16, r16;
    a16 = 16'(a);
    r16 = 16'(r);
    return {a16, r16, a16 * 16'd37 + r16 * 16'd101, 16'hA5C3 ^ 16'({1'b0, a, r})};
  endfunction

  // RFB: data for a request shows up LAT cycles after rfb_rd_en.
  logic [LAT-1:0] pv;
  logic [AW-1:0]  pa [LAT];
  logic [RW-1:0]  pr [LAT];
  always @(posedge clk_in) begin
    pv[0] <= bus.rfb_rd_en;
    pa[0] <= bus.rfb_rd_angle;
    pr[0] <= bus.rfb_rd_radius;
    for (int i = 1; i < int'(LAT); i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
      pr[i] <= pr[i-1];
    end
  end
  assign bus.rfb_rd_data = pv[LAT-1] ? rfb_word(pa[LAT-1], pr[LAT-1]) : 64'hBAD0_BAD0_BAD0_BAD0;

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (bus.rfb_rd_en) obs_rd.push_back({bus.rfb_rd_angle, bus.rfb_rd_radius});
      if (bus.cols_valid && bus.hub75_ready) obs_beat.push_back({bus.radii_out, bus.cols_out});
      if (bus.slice_done) done_cnt <= done_cnt + 1;
      if (bus.overrun) ovr_cnt <= ovr_cnt + 1;
    end
  end

  // Reference: a slice at angle a is SR pairs, each pair reads (a,p) then the
  // opposite angle at radius SR-1-p, and hands over both words.
  task automatic model_slice(input logic [AW-1:0] a);
    int b, q;
    b = (int'(a) + int'(ROT) / 2) % int'(ROT);
    for (int p = 0; p < int'(SR); p++) begin
      q = int'(SR) - 1 - p;
      exp_rd.push_back({a, RW'(p)});
      exp_rd.push_back({AW'(b), RW'(q)});
      exp_beat.push_back({RW'(q), RW'(p), rfb_word(AW'(b), RW'(q)), rfb_word(a, RW'(p))});
    end
    exp_done++;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic strobe(input logic [AW-1:0] a);
    bus.angle_in       = a;
    bus.angle_valid_in = 1'b1;
    tick();
    bus.angle_valid_in = 1'b0;
    bus.angle_in       = AW'($urandom);
  endtask

  task automatic wait_done(input int maxc, input int unsigned pct, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      bus.hub75_ready = ($urandom_range(0, 99) < pct);
      if (bus.slice_done) begin
        ok = 1'b1;
        break;
      end
    end
    bus.hub75_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.angle_in       = AW'($urandom);
      bus.angle_valid_in = 1'($urandom);
      bus.hub75_ready    = 1'($urandom);
      tick();
      n_vec++;
      if ({bus.rfb_rd_en, bus.rfb_rd_angle, bus.rfb_rd_radius, bus.radii_out, bus.cols_out,
           bus.cols_valid, bus.slice_done, bus.overrun} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got en=%b ang=%0d rad=%0d vld=%b done=%b ovr=%b, need all 0",
                 bus.rfb_rd_en, bus.rfb_rd_angle, bus.rfb_rd_radius, bus.cols_valid,
                 bus.slice_done, bus.overrun);
      end
    end
    bus.angle_valid_in = 1'b0;
    bus.hub75_ready    = 1'b1;
    rst_n_in           = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({bus.rfb_rd_en, bus.cols_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_release_idle: got en=%b vld=%b, need 0 0", bus.rfb_rd_en,
                 bus.cols_valid);
      end
    end
  endtask

  task automatic test_single_slice();
    int first_vld, t;
    int r0;
    r0 = obs_rd.size();
    first_vld = -1;
    model_slice(AW'(10));
    strobe(AW'(10));
    for (t = 1; t <= 2000; t++) begin
      tick();
      if (bus.cols_valid && first_vld < 0) first_vld = t;
      if (bus.slice_done) break;
    end
    tick();
    n_vec++;
    if (first_vld != int'(2 + LAT)) begin
      n_err++;
      $display("FAIL single_latency: got %0d cycles, need %0d", first_vld, 2 + LAT);
    end
    n_vec++;
    if (t != int'(SR * (3 + LAT))) begin
      n_err++;
      $display("FAIL single_slice_cycles: got %0d, need %0d", t, SR * (3 + LAT));
    end
    n_vec++;
    if (obs_rd.size() < r0 + 4) begin
      n_err++;
      $display("FAIL single_first_reads: got %0d reads, need >= 4", obs_rd.size() - r0);
    end else if ({obs_rd[r0], obs_rd[r0+1], obs_rd[r0+2], obs_rd[r0+3]} !==
                 {10'd10, 5'd0, 10'd522, 5'd31, 10'd10, 5'd1, 10'd522, 5'd30}) begin
      n_err++;
      $display("FAIL single_first_reads: got %h %h %h %h, need (10,0)(522,31)(10,1)(522,30)",
               obs_rd[r0], obs_rd[r0+1], obs_rd[r0+2], obs_rd[r0+3]);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] angs [2];
    logic [AW-1:0] opp  [2];
    int r0;
    bit ok;
    angs[0] = AW'(600);  opp[0] = AW'(88);
    angs[1] = AW'(1023); opp[1] = AW'(511);
    for (int k = 0; k < 2; k++) begin
      r0 = obs_rd.size();
      model_slice(angs[k]);
      strobe(angs[k]);
      wait_done(2000, 100, ok);
      tick();
      n_vec++;
      if (!ok || obs_rd.size() != r0 + int'(2 * SR)) begin
        n_err++;
        $display("FAIL wrap_done: got done=%b reads=%0d, need 1 %0d", ok, obs_rd.size() - r0,
                 2 * SR);
      end else begin
        for (int p = 0; p < int'(SR); p++) begin
          n_vec++;
          if (obs_rd[r0 + 2*p + 1][AW+RW-1:RW] !== opp[k]) begin
            n_err++;
            $display("FAIL wrap_side1_angle: got %0d, need %0d",
                     obs_rd[r0 + 2*p + 1][AW+RW-1:RW], opp[k]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a;
    beat_t held;
    bit seen, ok;
    a = AW'($urandom);
    bus.hub75_ready = 1'b1;
    model_slice(a);
    strobe(a);
    seen = 1'b0;
    for (int g = 0; g < 200 && !seen; g++) begin
      if (bus.cols_valid && bus.radii_out[0] == RW'(3)) seen = 1'b1;
      else tick();
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL bp_reach_pair3: got no pair 3 beat, need one");
    end else begin
      bus.hub75_ready = 1'b0;
      held = {bus.radii_out, bus.cols_out};
      for (int i = 0; i < 5; i++) begin
        tick();
        n_vec++;
        if ({bus.cols_valid, bus.rfb_rd_en, bus.radii_out, bus.cols_out} !== {2'b10, held}) begin
          n_err++;
          $display("FAIL bp_hold: got vld=%b en=%b radii=%h, need 1 0 %h", bus.cols_valid,
                   bus.rfb_rd_en, bus.radii_out, held[2*RW+2*NR-1:2*NR]);
        end
      end
      bus.hub75_ready = 1'b1;
      tick();
      n_vec++;
      if ({bus.rfb_rd_en, bus.rfb_rd_angle, bus.rfb_rd_radius} !== {1'b1, a, RW'(4)}) begin
        n_err++;
        $display("FAIL bp_next_read: got en=%b ang=%0d rad=%0d, need 1 %0d 4", bus.rfb_rd_en,
                 bus.rfb_rd_angle, bus.rfb_rd_radius, a);
      end
    end
    wait_done(2000, 100, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL bp_done: got timeout, need slice_done");
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, b;
    bit ok;
    a = AW'($urandom);
    b = AW'($urandom);
    model_slice(a);
    model_slice(b);
    strobe(a);
    tick(); tick(); tick();
    strobe(b);
    n_vec++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_overrun: got %b, need 0", bus.overrun);
    end
    wait_done(2000, 100, ok);
    tick();
    n_vec++;
    if (!ok || bus.rfb_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle_cycle: got done=%b en=%b, need 1 0", ok, bus.rfb_rd_en);
    end
    tick();
    n_vec++;
    if ({bus.rfb_rd_en, bus.rfb_rd_angle, bus.rfb_rd_radius} !== {1'b1, b, RW'(0)}) begin
      n_err++;
      $display("FAIL b2b_pending_start: got en=%b ang=%0d rad=%0d, need 1 %0d 0", bus.rfb_rd_en,
               bus.rfb_rd_angle, bus.rfb_rd_radius, b);
    end
    wait_done(2000, 100, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL b2b_done2: got timeout, need slice_done");
    end
  endtask

  task automatic test_overrun();
    int r0, hits;
    bit ok;
    r0 = obs_rd.size();
    model_slice(AW'(100));
    model_slice(AW'(300));
    exp_ovr++;
    strobe(AW'(100));
    for (int i = 0; i < 10; i++) tick();
    strobe(AW'(200));
    n_vec++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_first_pending: got %b, need 0", bus.overrun);
    end
    for (int i = 0; i < 10; i++) tick();
    strobe(AW'(300));
    n_vec++;
    if (bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_pulse: got %b, need 1", bus.overrun);
    end
    tick();
    n_vec++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_one_cycle: got %b, need 0", bus.overrun);
    end
    wait_done(2000, 100, ok);
    tick(); tick();
    n_vec++;
    if (!ok || {bus.rfb_rd_en, bus.rfb_rd_angle} !== {1'b1, 10'd300}) begin
      n_err++;
      $display("FAIL ovr_next_angle: got done=%b en=%b ang=%0d, need 1 1 300", ok,
               bus.rfb_rd_en, bus.rfb_rd_angle);
    end
    wait_done(2000, 100, ok);
    for (int i = 0; i < 6; i++) tick();
    hits = 0;
    for (int i = r0; i < obs_rd.size(); i++) begin
      if (obs_rd[i][AW+RW-1:RW] == AW'(200)) hits++;
    end
    n_vec++;
    if (!ok || hits != 0 || bus.rfb_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_drop_200: got done=%b reads_of_200=%0d en=%b, need 1 0 0", ok, hits,
               bus.rfb_rd_en);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a, b;
    bit ok;
    a = AW'($urandom);
    b = AW'($urandom);
    strobe(a);
    tick(); tick();
    // Pair 0 reads have been issued; the aborted slice contributes only those.
    exp_rd.push_back({a, RW'(0)});
    exp_rd.push_back({AW'((int'(a) + int'(ROT) / 2) % int'(ROT)), RW'(SR - 1)});
    rst_n_in = 1'b0;
    #1;
    n_vec++;
    if ({bus.rfb_rd_en, bus.rfb_rd_angle, bus.rfb_rd_radius, bus.radii_out, bus.cols_out,
         bus.cols_valid, bus.slice_done, bus.overrun} !== '0) begin
      n_err++;
      $display("FAIL midreset_async_clear: got en=%b vld=%b ang=%0d, need all 0", bus.rfb_rd_en,
               bus.cols_valid, bus.rfb_rd_angle);
    end
    tick(); tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({bus.cols_valid, bus.rfb_rd_en} !== 2'b00) begin
        n_err++;
        $display("FAIL midreset_quiet: got vld=%b en=%b, need 0 0", bus.cols_valid,
                 bus.rfb_rd_en);
      end
    end
    model_slice(b);
    strobe(b);
    wait_done(2000, 100, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL midreset_next_done: got timeout, need slice_done");
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      a = AW'($urandom);
      model_slice(a);
      strobe(a);
      wait_done(4000, 60, ok);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL random_done: got timeout on slice %0d, need slice_done", k);
      end
    end
  endtask

  task automatic test_streams();
    tick(); tick();
    n_vec++;
    if (obs_rd.size() != exp_rd.size()) begin
      n_err++;
      $display("FAIL stream_read_count: got %0d, need %0d", obs_rd.size(), exp_rd.size());
    end
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
      n_vec++;
      if (obs_rd[i] !== exp_rd[i]) begin
        n_err++;
        $display("FAIL stream_read[%0d]: got ang=%0d rad=%0d, need ang=%0d rad=%0d", i,
                 obs_rd[i][AW+RW-1:RW], obs_rd[i][RW-1:0], exp_rd[i][AW+RW-1:RW],
                 exp_rd[i][RW-1:0]);
      end
    end
    n_vec++;
    if (obs_beat.size() != exp_beat.size()) begin
      n_err++;
      $display("FAIL stream_beat_count: got %0d, need %0d", obs_beat.size(), exp_beat.size());
    end
    for (int i = 0; i < exp_beat.size() && i < obs_beat.size(); i++) begin
      n_vec++;
      if (obs_beat[i] !== exp_beat[i]) begin
        n_err++;
        $display("FAIL stream_beat[%0d]: got %h, need %h", i, obs_beat[i], exp_beat[i]);
      end
    end
    n_vec++;
    if (done_cnt != exp_done || ovr_cnt != exp_ovr) begin
      n_err++;
      $display("FAIL stream_pulses: got done=%0d ovr=%0d, need done=%0d ovr=%0d", done_cnt,
               ovr_cnt, exp_done, exp_ovr);
    end
  endtask

  initial begin
    bus.angle_in       = '0;
    bus.angle_valid_in = 1'b0;
    bus.hub75_ready    = 1'b1;
    test_reset();
    test_single_slice();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_random();
    test_streams();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
